// File: rtl/spi_tx_pkg.sv
// Shared types and constants for the SPI word serializer.
package spi_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_LOAD,
    ST_GAP
  } state_t;

  localparam int DEFAULT_WIDTH = 16;

  // Bit counter width: it holds WIDTH-1, and is at least one bit wide.
  function automatic int bit_cnt_w(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

  localparam int BIT_CNT_W = bit_cnt_w(DEFAULT_WIDTH);
  localparam int GAP_CNT_W = 4;

endpackage

// File: rtl/spi_tx_fifo.sv
// Small synchronous FIFO with a combinational read port (first-word fall-through).
module spi_tx_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign o_empty = (wr_ptr == rd_ptr);
  assign o_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty;
  assign o_data  = mem[rd_ptr[AW-1:0]];

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && do_push) begin
      mem[wr_ptr[AW-1:0]] <= i_data;
    end
  end

  // Pointer update; push and pop in the same cycle leave occupancy unchanged.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/spi_word_tx.sv
// Word serializer: buffers parallel words and shifts each out MSB-first,
// followed by a one-cycle load strobe and an optional idle gap.
module spi_word_tx
  import spi_tx_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int FIFO_DEPTH = 2,
  parameter int GAP        = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_word,
  input  logic             i_valid,
  output logic             o_ready,
  output logic             o_dat,
  output logic             o_load,
  output logic             o_busy,
  output logic [7:0]       o_frames
);

  localparam int BCW = bit_cnt_w(WIDTH);

  state_t               state;
  logic [WIDTH-1:0]     sr;
  logic [BCW-1:0]       bit_cnt;
  logic [GAP_CNT_W-1:0] gap_cnt;
  logic [7:0]           frames;
  logic                 dat_q;
  logic                 load_q;
  logic                 ready_en;

  logic [WIDTH-1:0]     fifo_rd_data;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;

  assign o_ready  = ready_en && i_rst_n && !fifo_full;
  assign push     = i_valid && o_ready;
  assign o_dat    = dat_q;
  assign o_load   = load_q;
  assign o_frames = frames;
  assign o_busy   = (state != ST_IDLE) || !fifo_empty;

  spi_tx_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push),
    .i_data  (i_word),
    .i_pop   (pop),
    .o_data  (fifo_rd_data),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  // Holds o_ready low until the first edge after reset is released.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) ready_en <= 1'b0;
    else          ready_en <= 1'b1;
  end

  // Pop decision: from IDLE, straight after LOAD when there is no gap, or on
  // the final gap cycle so the frame period stays WIDTH+1+GAP.
  always_comb begin
    pop = 1'b0;
    if (!fifo_empty) begin
      case (state)
        ST_IDLE:  pop = 1'b1;
        ST_LOAD:  pop = (GAP == 0);
        ST_GAP:   pop = (gap_cnt == '0);
        default:  pop = 1'b0;
      endcase
    end
  end

  // Frame FSM with shift register, counters and registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state   <= ST_IDLE;
      sr      <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      frames  <= '0;
      dat_q   <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      dat_q  <= 1'b0;
      load_q <= 1'b0;
      case (state)
        ST_IDLE: state <= ST_IDLE;
        ST_SHIFT: begin
          if (bit_cnt == '0) begin
            load_q <= 1'b1;
            frames <= frames + 8'd1;
            state  <= ST_LOAD;
          end else begin
            dat_q   <= sr[WIDTH-1];
            sr      <= {sr[WIDTH-2:0], 1'b0};
            bit_cnt <= bit_cnt - BCW'(1);
          end
        end
        ST_LOAD: begin
          if (GAP > 0) begin
            state   <= ST_GAP;
            gap_cnt <= GAP_CNT_W'(GAP - 1);
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_GAP: begin
          if (gap_cnt == '0) state <= ST_IDLE;
          else               gap_cnt <= gap_cnt - GAP_CNT_W'(1);
        end
        default: state <= ST_IDLE;
      endcase
      // A pop overrides the case above: the MSB goes straight onto o_dat and
      // the remaining bits are left in sr for SHIFT.
      if (pop) begin
        state   <= ST_SHIFT;
        dat_q   <= fifo_rd_data[WIDTH-1];
        sr      <= {fifo_rd_data[WIDTH-2:0], 1'b0};
        bit_cnt <= BCW'(WIDTH - 1);
      end
    end
  end

endmodule

// File: tb/tb_spi_word_tx.sv
// Scoreboard bench for spi_word_tx: a chain model shifts o_dat and a monitor
// checks each frame captured at o_load against the queue of pushed words.
module tb_spi_word_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [15:0] word = '0;
  logic        valid = 1'b0;
  logic        ready, dat, load, busy;
  logic [7:0]  frames;

  logic [15:0] g_word = '0;
  logic        g_valid = 1'b0;
  logic        g_ready, g_dat, g_load, g_busy;
  logic [7:0]  g_frames;

  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic [15:0] exp_q[$];
  int          load_cyc[$];
  logic [7:0]  mon_frames = '0;
  logic [15:0] chain_sh = '0;
  logic [15:0] chain_par = '0;

  always #5 clk = ~clk;

  spi_word_tx #(.WIDTH(16), .FIFO_DEPTH(2), .GAP(0)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_word(word), .i_valid(valid),
    .o_ready(ready), .o_dat(dat), .o_load(load), .o_busy(busy), .o_frames(frames)
  );

  spi_word_tx #(.WIDTH(16), .FIFO_DEPTH(2), .GAP(1)) u_gap (
    .i_clk(clk), .i_rst_n(rst_n), .i_word(g_word), .i_valid(g_valid),
    .o_ready(g_ready), .o_dat(g_dat), .o_load(g_load), .o_busy(g_busy), .o_frames(g_frames)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Chain model: shifts o_dat every edge, transfers to parallel on o_load.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (load) chain_par <= chain_sh;
    else      chain_sh  <= {chain_sh[14:0], dat};
  end

  // Monitor: on each load pulse compare the shifted frame with the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_frames = '0;
    end else if (load) begin
      load_cyc.push_back(cyc);
      check("load_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("frame_word", 32'(chain_sh), 32'(exp_q.pop_front()));
      mon_frames = mon_frames + 8'd1;
      check("frame_count", 32'(frames), 32'(mon_frames));
      check("dat_in_load", 32'(dat), 32'd0);
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; valid = 1'b0; g_valid = 1'b0;
    exp_q.delete();
    load_cyc.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the handshake with
  // i_valid still high so consecutive calls push on consecutive edges.
  task automatic send(input logic [15:0] w, output int waits);
    waits = 0; word = w; valid = 1'b1;
    while (!ready && waits < 500) begin
      @(negedge clk);
      waits++;
    end
    if (ready) begin
      exp_q.push_back(w);
      @(negedge clk);
    end else begin
      check("send_ready", 32'(ready), 32'd1);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    valid = 1'b0;
    while ((busy || exp_q.size() > 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("drain_in_time", 32'(t < 3000), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          w;
    logic [15:0] got;
    int          nload;
    logic [15:0] v;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_dat",   32'(dat),   32'd0);
    check("rst_load",  32'(load),  32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_frames", 32'(frames), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(ready), 32'd1);
    check("g_ready_after_rst", 32'(g_ready), 32'd1);

    // Single word at GAP=1
    g_word = 16'hA5C3; g_valid = 1'b1;
    @(negedge clk);
    g_valid = 1'b0;
    got = '0; nload = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      got = {got[14:0], g_dat};
      nload += int'(g_load);
    end
    check("g_serial_word", 32'(got), 32'hA5C3);
    check("g_load_during_bits", nload, 0);
    @(negedge clk);
    check("g_load_pulse", 32'(g_load), 32'd1);
    check("g_frames", 32'(g_frames), 32'd1);
    @(negedge clk);
    check("g_load_gap", 32'(g_load), 32'd0);
    check("g_busy_gap", 32'(g_busy), 32'd1);
    @(negedge clk);
    check("g_busy_after_gap", 32'(g_busy), 32'd0);

    // Back-to-back at GAP=0
    apply_reset();
    send(16'hFFFF, w);
    send(16'h0001, w);
    wait_idle();
    check("b2b_loads", load_cyc.size(), 2);
    if (load_cyc.size() == 2) check("b2b_period", load_cyc[1] - load_cyc[0], 17);
    check("b2b_frames", 32'(frames), 32'd2);

    // Backpressure with FIFO_DEPTH=2
    apply_reset();
    send(16'h1357, w);
    send(16'h2468, w);
    send(16'h9ABC, w);
    check("bp_ready_full", 32'(ready), 32'd0);
    send(16'hDEF0, w);
    check("bp_wait_cycles", w, 16);
    wait_idle();
    check("bp_frames", 32'(frames), 32'd4);

    // Reset mid-frame during bit 8
    send(16'h1234, w);
    valid = 1'b0;
    repeat (9) @(negedge clk);
    v = 16'h1234;
    check("mid_bit8", 32'(dat), 32'(v[7]));
    rst_n = 1'b0;
    exp_q.delete();
    load_cyc.delete();
    @(negedge clk);
    check("mid_rst_dat", 32'(dat), 32'd0);
    check("mid_rst_load", 32'(load), 32'd0);
    check("mid_rst_frames", 32'(frames), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("mid_no_load", load_cyc.size(), 0);
    check("mid_idle_busy", 32'(busy), 32'd0);

    // Loopback into the chain model
    apply_reset();
    send(16'hBEEF, w);
    wait_idle();
    check("loopback_par", 32'(chain_par), 32'hBEEF);

    // Frame counter wrap
    apply_reset();
    for (int i = 0; i < 256; i++) begin
      send(16'(i * 37) ^ 16'hA55A, w);
    end
    wait_idle();
    check("wrap_loads", load_cyc.size(), 256);
    check("wrap_frames", 32'(frames), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_word_tx.md
# spi_word_tx

Upstream word serializer for the on-chip shift/detect chain. Accepts 16-bit words over a valid/ready handshake and buffers them in a small FIFO. Each word is shifted out MSB-first on a one-bit-per-clock serial line, then the chain's load strobe pulses for one cycle. It drives the chain's `i_dat`/`i_load` inputs directly, from the same clock, so a host-side block can push parallel words without bit-banging the pins.

## Interface
- `WIDTH`, 16: word / frame length in bits (≥2).
- `FIFO_DEPTH`, 2: input buffer entries (power of two, ≥2).
- `GAP`, 1: idle cycles inserted after each load pulse (0..15).

- `i_clk`  in  1  single clock; all logic on rising edge.
- `i_rst_n`  in  1  reset, synchronous, active-low.
- `i_word`  in  WIDTH  parallel word to transmit.
- `i_valid`  in  1  `i_word` valid.
- `o_ready`  out  1  FIFO can accept a word this cycle.
- `o_dat`  out  1  serial data to the chain, registered.
- `o_load`  out  1  one-cycle load strobe to the chain, registered.
- `o_busy`  out  1  FSM not in IDLE, or FIFO non-empty.
- `o_frames`  out  8  completed-frame counter, wraps 255→0.

## Operation
- Push: `i_valid && o_ready` at a rising edge writes `i_word` into the FIFO. `o_ready = !full`, and `o_ready` is 0 while in reset.
- FSM states: IDLE, SHIFT, LOAD, GAP.
- IDLE:
  - If FIFO non-empty, pop into shift register `sr`, set bit counter to WIDTH-1, go to SHIFT.
  - Otherwise stay; `o_dat=0`, `o_load=0`.
- SHIFT:
  - `o_dat = sr[WIDTH-1]`; `sr` shifts left by one each cycle, zero-filled.
  - Counter decrements; after the WIDTH-th bit, go to LOAD.
- LOAD:
  - `o_load=1`, `o_dat=0` for exactly one cycle; `o_frames` increments.
  - If GAP>0, go to GAP.
  - If GAP==0 and FIFO non-empty, pop and go directly to SHIFT (back-to-back).
  - Otherwise go to IDLE.
- GAP: `o_dat=0` for GAP cycles, then IDLE.
- Simultaneous push and pop in the same cycle are both honoured; occupancy is unchanged.
- Reset (any state, including mid-frame):
  - FIFO flushed, FSM to IDLE, `sr` and counters to 0.
  - The current frame is abandoned; no `o_load` for it.
- Reset values: `o_dat=0`, `o_load=0`, `o_busy=0`, `o_frames=0`, `o_ready=0`. `o_ready` rises the first cycle after `i_rst_n` goes high.

## Timing
- Latency: handshake at edge E0. FIFO visible at E0; FSM pops at edge E1. MSB is on `o_dat` from E1 until E1+1.
- Bit k (MSB=0) is on `o_dat` during cycle E1+k. `o_load` is high during cycle E1+WIDTH.
- Frame period: WIDTH+1+GAP cycles when the FIFO stays non-empty. At GAP=0 this is 17 cycles per word; with a continuously valid source the pipeline sustains one word per 17 cycles.
- Consumer contract: the chain samples `o_dat` every edge. The last WIDTH bits sampled before the `o_load` edge are exactly the word, MSB first.
- `o_busy` is combinational from state and FIFO count. It drops in the cycle after the last LOAD/GAP cycle when the FIFO is empty.
- FIFO full with `i_valid` high: `o_ready=0` and the word is not taken. The source holds the word until ready.

## Structure
- Package `spi_tx_pkg`:
  - state enum {IDLE, SHIFT, LOAD, GAP}
  - default WIDTH constant
  - counter width localparams: `$clog2(WIDTH)` for the bit counter, 4 bits for the gap counter
- Sub-module `spi_tx_fifo`: synchronous FIFO, parameterised on WIDTH/FIFO_DEPTH, with push/pop/full/empty and synchronous active-low reset.
- Top module contains FSM, shift register, bit/gap counters and frame counter.

## Test plan
- Single word: push 16'hA5C3 after reset, GAP=1. Response:
  - `o_dat` shows 1010010111000011 over 16 cycles starting 2 edges after the handshake.
  - `o_load` pulses once on the next cycle; `o_frames`=1.
  - `o_busy` falls after one gap cycle.
- Back-to-back at GAP=0: push 16'hFFFF then 16'h0001 on consecutive cycles. Response:
  - First `o_load` is followed immediately by 15 zeros and a 1.
  - Second `o_load` comes exactly 17 cycles after the first.
  - No idle cycle between frames.
- Backpressure at FIFO_DEPTH=2: hold `i_valid` with 3 distinct words. Response:
  - `o_ready` drops after the FIFO fills.
  - The third word is accepted only after the first pop.
  - All three frames appear in order, and `o_frames`=3.
- Reset mid-frame: assert `i_rst_n`=0 during bit 8 of 16'h1234. Response:
  - Next cycle `o_dat`=0, `o_load`=0, `o_frames`=0, FIFO empty.
  - No load pulse follows release.
- Counter wrap: transmit 256 frames. Response:
  - `o_frames` reads 255 after frame 255 and 0 after frame 256.
- Loopback with the chain: drive the chain from this block with word 16'hBEEF. Response:
  - The chain's parallel output reads 16'hBEEF after `o_load`.
